legv8_data_mem: RTL and testbench
=================================

# legv8_data_mem

Parametrised data memory for the LEGv8 datapath, successor to the single-cycle 256×64 data RAM. It adds byte-addressed sub-word access (byte/half/word/dword) with a valid/ready request handshake and a configurable number of wait states, so the pipeline can be exercised against slow memory. It keeps a contiguous window of words exposed on debug taps for board display and testbench checking.

## Interface
Parameters:
- DATA_W, 64, word width in bits; power of two, ≥ 8.
- ADDR_W, 11, byte-address width; DEPTH = 2^(ADDR_W − log2(DATA_W/8)) words.
- WAIT_CYCLES, 1, extra wait states per access, 0–15.
- TAP_BASE, 1, first word index exposed on taps.
- TAP_N, 4, number of tapped words, ≥ 1; TAP_BASE+TAP_N ≤ DEPTH.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle response strobe (loads and stores).
- rsp_rdata  out  DATA_W  load data, zero-extended, right-justified; 0 for stores.
- rsp_err  out  1  access rejected (see Configuration).
- busy  out  1  high in WAIT or RESP.
- tap_data  out  TAP_N*DATA_W  word TAP_BASE+i on bits [i*DATA_W +: DATA_W], combinational.

## Operation
- Access bytes B = min(2^req_size, DATA_W/8); lane offset = req_addr mod (DATA_W/8); word index = req_addr / (DATA_W/8).
- FSM states IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at an edge: latch we/size/addr/wdata, cnt←WAIT_CYCLES, go WAIT.
- WAIT: if cnt≠0, decrement; if cnt=0, perform the access at that edge and go RESP.
- Access: store merges B bytes of req_wdata[8B−1:0] into lanes offset..offset+B−1 (little-endian), other lanes untouched; load captures those lanes into rsp_rdata, upper bits 0.
- RESP: rsp_valid=1 exactly one cycle, rsp_rdata/rsp_err held; go IDLE next edge. No response backpressure.
- rsp_rdata and rsp_err hold their last values until the next RESP; meaningful only when rsp_valid=1.
- Memory array has no reset; contents are X until written.

## Timing
- Accept at edge k; access at edge k+WAIT_CYCLES+1; rsp_valid high between edges k+WAIT_CYCLES+1 and k+WAIT_CYCLES+2; req_ready high again after edge k+WAIT_CYCLES+2. Throughput: one access per WAIT_CYCLES+3 cycles.
- tap_data reflects a store from the cycle following its access edge.
- Reset values: state IDLE, cnt 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, req_ready 1 once reset_n is high.
- Reset asserted in WAIT or RESP, including coincident with the access edge: request dropped, no memory write, no rsp_valid.
- Requests while busy are ignored; the master holds req_valid/fields until accepted.

## Configuration
- LEGV8_DMEM_ALIGN_CHK_EN defined: an access whose lane offset is not a multiple of 2^req_size, or whose 2^req_size > DATA_W/8, is rejected. There is no memory write, rsp_rdata=0, rsp_err=1, and the full latency applies.
- Undefined: the address is aligned down to a multiple of B, and req_size is clamped to DATA_W/8. rsp_err is tied 0.

## Test plan
(DATA_W=64, ADDR_W=11, WAIT_CYCLES=1, TAP_BASE=1, TAP_N=4 unless noted)
- Reset, then dword store 0x0123456789ABCDEF at 0x008 accepted at edge k → rsp_valid only in cycle after edge k+2, tap word 0 = 0x0123456789ABCDEF, req_ready back after edge k+3.
- Byte store 0xAA at 0x00B → tap word 0 = 0x01234567AAABCDEF. Half load at 0x00A → rsp_rdata 0x000000000000AAAB, rsp_err 0.
- Word load at 0x00A: with macro → rsp_err 1, rsp_rdata 0. Without macro → rsp_rdata 0x00000000AAABCDEF, rsp_err 0.
- req_valid held continuously with two stores (0x010←0x11, 0x018←0x22) → second accepted only when req_ready returns; req_ready low for exactly 3 cycles per request; taps words 1,2 = 0x11, 0x22.
- Dword store 0xFFFF at 0x020 with reset_n pulsed low during WAIT → tap word 3 unchanged, no rsp_valid, req_ready 1 after release.
- WAIT_CYCLES=0 instance: load accepted at edge k → rsp_valid in cycle after edge k+1, returns previously stored value.

Source files
------------

// File: rtl/legv8_data_mem.sv
// Byte-addressed LEGv8 data memory with valid/ready requests, programmable wait states and debug word taps.
// Optional alignment checking is enabled by defining LEGV8_DMEM_ALIGN_CHK_EN.
module legv8_data_mem #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 11,
    parameter int WAIT_CYCLES = 1,
    parameter int TAP_BASE    = 1,
    parameter int TAP_N       = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [TAP_N*DATA_W-1:0] tap_data
);

    localparam int unsigned BPW    = DATA_W / 8;
    localparam int          LANE_W = $clog2(BPW);
    localparam int          IDX_W  = ADDR_W - LANE_W;
    localparam int          DEPTH  = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    // No reset on the array: contents stay undefined until written.
    logic [DATA_W-1:0]   r_mem [DEPTH];

    int unsigned         w_req_bytes;
    int unsigned         w_bytes;
    int unsigned         w_off;
    logic                w_err;
    logic [BPW-1:0]      w_lane_mask;
    logic [DATA_W-1:0]   w_data_mask;
    logic [DATA_W-1:0]   w_wdata_sh;
    logic [DATA_W-1:0]   w_rdata;
    logic [IDX_W-1:0]    w_idx;
    logic                w_access;
    logic                w_do_write;

    assign w_idx = r_addr[ADDR_W-1:LANE_W];

    always_comb begin
        w_req_bytes = 32'd1 << r_size;
        w_off       = 32'(r_addr) % BPW;
`ifdef LEGV8_DMEM_ALIGN_CHK_EN
        w_bytes     = w_req_bytes;
        w_err       = (w_req_bytes > BPW) || ((w_off % w_req_bytes) != 0);
`else
        // Clamp oversize requests to a full word, then align down to the access size.
        w_bytes     = (w_req_bytes > BPW) ? BPW : w_req_bytes;
        w_off       = w_off - (w_off % w_bytes);
        w_err       = 1'b0;
`endif
        w_lane_mask = '0;
        w_data_mask = '0;
        for (int unsigned j = 0; j < BPW; j++) begin
            w_lane_mask[j]        = (j >= w_off) && (j < w_off + w_bytes);
            w_data_mask[j*8 +: 8] = {8{j < w_bytes}};
        end
        w_wdata_sh  = r_wdata << (w_off * 8);
    end

    assign w_rdata    = (r_mem[w_idx] >> (w_off * 8)) & w_data_mask;
    assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    // Gating with reset_n blocks a write when reset coincides with the access edge.
    assign w_do_write = w_access && r_we && !w_err && reset_n;

    always_ff @(posedge clock) begin
        if (w_do_write) begin
            for (int unsigned j = 0; j < BPW; j++) begin
                if (w_lane_mask[j]) begin
                    r_mem[w_idx][j*8 +: 8] <= w_wdata_sh[j*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_err       <= w_err;
                        r_rdata     <= (r_we || w_err) ? '0 : w_rdata;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = reset_n && (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    generate
        for (genvar gi = 0; gi < TAP_N; gi++) begin : g_tap
            assign tap_data[gi*DATA_W +: DATA_W] = r_mem[TAP_BASE + gi];
        end
    endgenerate

endmodule

// File: tb/tb_legv8_data_mem.sv
// Self-checking bench for legv8_data_mem: directed scenarios plus randomized accesses
// checked against a byte-addressed reference memory.
module tb_legv8_data_mem;

    localparam int WC = 1;

    logic         clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_n, req_valid, req_ready, req_we, rsp_valid, rsp_err, busy;
    logic [1:0]   req_size;
    logic [10:0]  req_addr;
    logic [63:0]  req_wdata, rsp_rdata;
    logic [255:0] tap_data;

    logic         reset0_n, req_valid0, req_ready0, req_we0, rsp_valid0, rsp_err0, busy0;
    logic [1:0]   req_size0;
    logic [10:0]  req_addr0;
    logic [63:0]  req_wdata0, rsp_rdata0;
    logic [255:0] tap_data0;

    legv8_data_mem #(.DATA_W(64), .ADDR_W(11), .WAIT_CYCLES(WC), .TAP_BASE(1), .TAP_N(4)) u_dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .tap_data(tap_data)
    );

    legv8_data_mem #(.DATA_W(64), .ADDR_W(11), .WAIT_CYCLES(0), .TAP_BASE(1), .TAP_N(4)) u_w0 (
        .clock(clock), .reset_n(reset0_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_size(req_size0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0),
        .tap_data(tap_data0)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: plain byte-addressed memory.
    logic [7:0] mbytes [0:2047];

    function automatic logic [63:0] tap(input int i);
        return tap_data[i*64 +: 64];
    endfunction

    task automatic model_apply(input logic we, input logic [1:0] size, input logic [10:0] addr,
                               input logic [63:0] wdata, output logic [63:0] exp_rd,
                               output logic exp_err);
        int b;
        int a;
        b       = 1 << size;
        exp_rd  = '0;
        exp_err = 1'b0;
`ifdef LEGV8_DMEM_ALIGN_CHK_EN
        if ((int'(addr) % b) != 0) begin
            exp_err = 1'b1;
            return;
        end
        a = int'(addr);
`else
        a = int'(addr) - (int'(addr) % b);
`endif
        for (int i = 0; i < b; i++) begin
            if (we) mbytes[a + i] = wdata[8*i +: 8];
            else    exp_rd[8*i +: 8] = mbytes[a + i];
        end
    endtask

    // lat = number of edges after the accept edge at which rsp_valid is first seen.
    task automatic do_req(input logic we, input logic [1:0] size, input logic [10:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rd, output logic er,
                          output int lat, output logic ready_back);
        int g;
        @(negedge clock);
        req_we = we; req_size = size; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clock);
            g++;
        end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clock);
        ready_back = req_ready && !rsp_valid;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; reset0_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_size0 = 2'd0; req_addr0 = '0; req_wdata0 = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1; reset0_n = 1'b1;
        @(negedge clock);
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready=%b busy=%b rsp_valid=%b, required 1 0 0", req_ready, busy, rsp_valid);
        end
        tests_run++;
        if (rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rsp: rdata=%h err=%b, required 0 0", rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_dword_store;
        logic [63:0] rd, er_d;
        logic er, rb;
        int lat;
        do_req(1'b1, 2'd3, 11'h008, 64'h0123456789ABCDEF, rd, er, lat, rb);
        model_apply(1'b1, 2'd3, 11'h008, 64'h0123456789ABCDEF, er_d, er_d[0]);
        tests_run++;
        if (lat !== WC + 1 || rb !== 1'b1) begin
            tests_failed++;
            $display("FAIL dword_store_timing: lat=%0d ready_back=%b, required %0d 1", lat, rb, WC + 1);
        end
        tests_run++;
        if (rd !== 64'd0 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL dword_store_rsp: rdata=%h err=%b, required 0 0", rd, er);
        end
        tests_run++;
        if (tap(0) !== 64'h0123456789ABCDEF) begin
            tests_failed++;
            $display("FAIL dword_store_tap: tap0=%h, required 0123456789abcdef", tap(0));
        end
    endtask

    task automatic test_byte_half;
        logic [63:0] rd, ed;
        logic er, ee, rb;
        int lat;
        do_req(1'b1, 2'd0, 11'h00B, 64'hAA, rd, er, lat, rb);
        model_apply(1'b1, 2'd0, 11'h00B, 64'hAA, ed, ee);
        tests_run++;
        if (tap(0) !== 64'h01234567AAABCDEF) begin
            tests_failed++;
            $display("FAIL byte_store_tap: tap0=%h, required 01234567aaabcdef", tap(0));
        end
        do_req(1'b0, 2'd1, 11'h00A, 64'h0, rd, er, lat, rb);
        model_apply(1'b0, 2'd1, 11'h00A, 64'h0, ed, ee);
        tests_run++;
        if (rd !== 64'h000000000000AAAB || er !== 1'b0 || lat !== WC + 1) begin
            tests_failed++;
            $display("FAIL half_load: rdata=%h err=%b lat=%0d, required aaab 0 %0d", rd, er, lat, WC + 1);
        end
    endtask

    task automatic test_misaligned;
        logic [63:0] rd, ed;
        logic er, ee, rb;
        int lat;
        do_req(1'b0, 2'd2, 11'h00A, 64'h0, rd, er, lat, rb);
        model_apply(1'b0, 2'd2, 11'h00A, 64'h0, ed, ee);
        tests_run++;
`ifdef LEGV8_DMEM_ALIGN_CHK_EN
        if (rd !== 64'd0 || er !== 1'b1 || lat !== WC + 1) begin
            tests_failed++;
            $display("FAIL word_load_misaligned: rdata=%h err=%b lat=%0d, required 0 1 %0d", rd, er, lat, WC + 1);
        end
`else
        if (rd !== 64'h00000000AAABCDEF || er !== 1'b0 || lat !== WC + 1) begin
            tests_failed++;
            $display("FAIL word_load_misaligned: rdata=%h err=%b lat=%0d, required aaabcdef 0 %0d", rd, er, lat, WC + 1);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int n_acc, run, pulses;
        int runs[$];
        logic [63:0] ed;
        logic ee;
        n_acc = 0; run = 0; pulses = 0;
        @(negedge clock);
        req_we = 1'b1; req_size = 2'd3; req_addr = 11'h010; req_wdata = 64'h11; req_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (rsp_valid) pulses++;
            if (req_ready) begin
                if (n_acc > 0) runs.push_back(run);
                run = 0;
                if (n_acc == 2) break;
                if (req_valid) n_acc++;
            end else begin
                run++;
            end
            @(posedge clock);
            @(negedge clock);
            if (n_acc == 1) begin
                req_addr = 11'h018; req_wdata = 64'h22;
            end else if (n_acc == 2) begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        model_apply(1'b1, 2'd3, 11'h010, 64'h11, ed, ee);
        model_apply(1'b1, 2'd3, 11'h018, 64'h22, ed, ee);
        tests_run++;
        if (runs.size() != 2 || runs[0] != WC + 2 || runs[1] != WC + 2 || pulses != 2) begin
            tests_failed++;
            $display("FAIL b2b_ready_gaps: n_runs=%0d gap0=%0d gap1=%0d pulses=%0d, required 2 %0d %0d 2",
                     runs.size(), (runs.size() > 0) ? runs[0] : -1, (runs.size() > 1) ? runs[1] : -1,
                     pulses, WC + 2, WC + 2);
        end
        tests_run++;
        if (tap(1) !== 64'h11 || tap(2) !== 64'h22) begin
            tests_failed++;
            $display("FAIL b2b_taps: tap1=%h tap2=%h, required 11 22", tap(1), tap(2));
        end
    endtask

    task automatic test_reset_abort;
        logic [63:0] v, rd, ed;
        logic er, ee, rb, seen;
        int lat, g;
        v = {$urandom, $urandom};
        do_req(1'b1, 2'd3, 11'h020, v, rd, er, lat, rb);
        model_apply(1'b1, 2'd3, 11'h020, v, ed, ee);
        tests_run++;
        if (tap(3) !== v) begin
            tests_failed++;
            $display("FAIL abort_setup_tap: tap3=%h, required %h", tap(3), v);
        end
        @(negedge clock);
        req_we = 1'b1; req_size = 2'd3; req_addr = 11'h020; req_wdata = 64'hFFFF; req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clock);
            g++;
        end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        reset_n = 1'b0;
        seen = rsp_valid;
        @(negedge clock);
        seen = seen | rsp_valid;
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clock);
            seen = seen | rsp_valid;
        end
        tests_run++;
        if (seen !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_ctrl: rsp_seen=%b ready=%b busy=%b, required 0 1 0", seen, req_ready, busy);
        end
        tests_run++;
        if (tap(3) !== v) begin
            tests_failed++;
            $display("FAIL abort_tap: tap3=%h, required %h", tap(3), v);
        end
    endtask

    task automatic test_wait0;
        logic [63:0] v;
        int lat, g;
        v = {$urandom, $urandom};
        for (int op = 0; op < 2; op++) begin
            @(negedge clock);
            req_we0 = (op == 0); req_size0 = 2'd3; req_addr0 = 11'h040; req_wdata0 = v; req_valid0 = 1'b1;
            g = 0;
            while (!req_ready0 && g < 50) begin
                @(negedge clock);
                g++;
            end
            @(posedge clock);
            @(negedge clock);
            req_valid0 = 1'b0;
            lat = 0;
            while (!rsp_valid0 && lat < 50) begin
                @(negedge clock);
                lat++;
            end
            tests_run++;
            if (lat !== 1 || rsp_rdata0 !== ((op == 0) ? 64'd0 : v) || rsp_err0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL wait0_op%0d: lat=%0d rdata=%h err=%b, required 1 %h 0",
                         op, lat, rsp_rdata0, rsp_err0, (op == 0) ? 64'd0 : v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random;
        logic [63:0] wd, rd, ed;
        logic [1:0]  sz;
        logic [10:0] ad;
        logic        we, er, ee, rb;
        int lat, bad;
        for (int w = 0; w < 32; w++) begin
            wd = {$urandom, $urandom};
            do_req(1'b1, 2'd3, 11'(w * 8), wd, rd, er, lat, rb);
            model_apply(1'b1, 2'd3, 11'(w * 8), wd, ed, ee);
        end
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            ad = 11'($urandom_range(0, 255));
            wd = {$urandom, $urandom};
            model_apply(we, sz, ad, wd, ed, ee);
            do_req(we, sz, ad, wd, rd, er, lat, rb);
            tests_run++;
            if (rd !== ed || er !== ee || lat !== WC + 1 || rb !== 1'b1) begin
                tests_failed++;
                $display("FAIL rand_%0d we=%b size=%0d addr=%h: rdata=%h err=%b lat=%0d rb=%b, required %h %b %0d 1",
                         n, we, sz, ad, rd, er, lat, rb, ed, ee, WC + 1);
            end
        end
        bad = 0;
        for (int t = 0; t < 4; t++) begin
            for (int b = 0; b < 8; b++) begin
                if (tap(t)[8*b +: 8] !== mbytes[(t + 1) * 8 + b]) bad++;
            end
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL rand_taps: %0d tap bytes differ from model, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_dword_store();
        test_byte_half();
        test_misaligned();
        test_back_to_back();
        test_reset_abort();
        test_wait0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
